// File: rtl/cpu16_pkg.sv
// Shared ISA encodings, control codes and FSM state type for the 16-bit
// multicycle datapath.
package cpu16_pkg;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_SW   = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_SLL = 4'd2;
  localparam logic [3:0] FN_AND = 4'd3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_FAULT
  } state_e;

  typedef enum logic [2:0] {
    CL_R,
    CL_LW,
    CL_SW,
    CL_ADDI,
    CL_BEQ,
    CL_BNE,
    CL_JMP
  } iclass_e;

endpackage

// File: rtl/isa_decoder.sv
// Combinational opcode/funct classifier; flags every encoding outside the
// supported instruction set as illegal.
module isa_decoder
  import cpu16_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [3:0] funct_i,
  output iclass_e    iclass_o,
  output logic       illegal_o
);

  always_comb begin
    iclass_o  = CL_R;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        iclass_o  = CL_R;
        illegal_o = (funct_i > FN_AND);
      end
      OP_LW:   iclass_o = CL_LW;
      OP_SW:   iclass_o = CL_SW;
      OP_ADDI: iclass_o = CL_ADDI;
      OP_BEQ:  iclass_o = CL_BEQ;
      OP_BNE:  iclass_o = CL_BNE;
      OP_JMP:  iclass_o = CL_JMP;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control FSM with memory handshake, timeout watchdog
// and a sticky FAULT state.
module multicycle_sequencer
  import cpu16_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        wb_sel,
  output logic        alu_src,
  output logic [3:0]  alu_op,
  output logic        retire,
  output logic        fault
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  iclass_e       cls_q, dec_cls;
  logic [3:0]    funct_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          fetch_busy_q, fetch_busy_d;
  logic          dec_illegal;
  logic          ir_unused;

  assign ir_unused = ^ir[11:4];

  isa_decoder u_dec (
    .opcode_i  (ir[15:12]),
    .funct_i   (ir[3:0]),
    .iclass_o  (dec_cls),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = PC_INC;
    reg_we  = 1'b0;
    reg_dst = 1'b0;
    wb_sel  = 1'b0;
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    retire  = 1'b0;
    fault   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // A fetch already issued stays requested even if run falls before ack.
        mem_req = run | fetch_busy_q;
        if (mem_req && mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = PC_INC;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_FAULT;
        end else if (dec_cls == CL_JMP) begin
          pc_we   = 1'b1;
          pc_sel  = PC_JUMP;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CL_R: begin
            alu_op  = funct_q;
            state_d = ST_WB;
          end
          CL_ADDI: begin
            alu_src = 1'b1;
            state_d = ST_WB;
          end
          CL_LW, CL_SW: begin
            alu_src = 1'b1;
            state_d = ST_MEM;
          end
          default: begin
            alu_op = ALU_SUB;
            if ((cls_q == CL_BEQ && alu_zero) || (cls_q == CL_BNE && !alu_zero)) begin
              pc_we  = 1'b1;
              pc_sel = PC_BRANCH;
            end
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CL_SW);
        if (mem_ack) begin
          if (cls_q == CL_SW) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        reg_dst = (cls_q == CL_R);
        wb_sel  = (cls_q == CL_LW);
        state_d = ST_FETCH;
      end
      default: begin
        fault = 1'b1;
      end
    endcase

    if (mem_req && !mem_ack && tmo_q == TMO_LAST) begin
      state_d = ST_FAULT;
    end

    if (!rst_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      pc_sel  = PC_INC;
      reg_we  = 1'b0;
      reg_dst = 1'b0;
      wb_sel  = 1'b0;
      alu_src = 1'b0;
      alu_op  = ALU_ADD;
      retire  = 1'b0;
      fault   = 1'b0;
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (mem_req && !mem_ack) begin
      tmo_d = tmo_q + 1'b1;
    end
    fetch_busy_d = (state_q == ST_FETCH) && (state_d == ST_FETCH) && mem_req && !mem_ack;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      tmo_q        <= '0;
      fetch_busy_q <= 1'b0;
      cls_q        <= CL_R;
      funct_q      <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      fetch_busy_q <= fetch_busy_d;
      if (state_q == ST_DECODE) begin
        cls_q   <= dec_cls;
        funct_q <= ir[3:0];
      end
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: each driven cycle queues the expected control word, which
// is compared against the DUT outputs on the following falling edge.
module tb_multicycle_sequencer;

  typedef struct packed {
    logic       fault;
    logic       retire;
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic       reg_dst;
    logic       wb_sel;
    logic       alu_src;
    logic [3:0] alu_op;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] ir = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, ir_we, pc_we, reg_we, reg_dst, wb_sel, alu_src, retire, fault;
  logic [1:0]  pc_sel;
  logic [3:0]  alu_op;
  outs_t       act;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  outs_t       exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir(ir), .alu_zero(alu_zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op), .retire(retire),
    .fault(fault)
  );

  assign act = {fault, retire, mem_req, mem_we, ir_we, pc_we, pc_sel,
                reg_we, reg_dst, wb_sel, alu_src, alu_op};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) check(tag_q.pop_front(), act, exp_q.pop_front());
  end

  task automatic cyc(input logic r, input logic a, input string tag, input outs_t e);
    run     = r;
    mem_ack = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    outs_t e;
    e = '0;
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, "reset", e);
    cyc(1'b1, 1'b1, "reset", e);
    rst_n = 1'b1;
  endtask

  // Drives one instruction with fw fetch wait cycles and mw MEM wait cycles.
  task automatic instr(input logic [15:0] i, input logic z, input int unsigned fw,
                       input int unsigned mw, input string nm);
    outs_t e;
    logic [3:0] op, fn;
    op = i[15:12];
    fn = i[3:0];
    alu_zero = z;
    ir = 16'hF00F;
    for (int unsigned k = 0; k < fw; k++) begin
      e = '0; e.mem_req = 1'b1;
      cyc(k == 0, 1'b0, {nm, ".fwait"}, e);
    end
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    cyc(fw == 0, 1'b1, {nm, ".fetch"}, e);
    ir = i;
    if (op > 4'd6 || (op == 4'd0 && fn > 4'd3)) begin
      e = '0;
      cyc(1'b0, 1'b0, {nm, ".decode"}, e);
      e = '0; e.fault = 1'b1;
      for (int unsigned k = 0; k < 3; k++) cyc(1'b1, 1'b1, {nm, ".fault"}, e);
      return;
    end
    e = '0;
    if (op == 4'd6) begin
      e.pc_we = 1'b1; e.pc_sel = 2'b10; e.retire = 1'b1;
      cyc(1'b0, 1'b0, {nm, ".decode"}, e);
      return;
    end
    cyc(1'b0, 1'b0, {nm, ".decode"}, e);
    e = '0;
    if (op == 4'd4 || op == 4'd5) begin
      e.alu_op = 4'd1; e.retire = 1'b1;
      if ((op == 4'd4) == z) begin
        e.pc_we = 1'b1; e.pc_sel = 2'b01;
      end
      cyc(1'b0, 1'b0, {nm, ".exec"}, e);
      return;
    end
    if (op == 4'd0) e.alu_op = fn;
    else e.alu_src = 1'b1;
    cyc(1'b0, 1'b0, {nm, ".exec"}, e);
    if (op == 4'd1 || op == 4'd2) begin
      e = '0; e.mem_req = 1'b1; e.mem_we = (op == 4'd2);
      for (int unsigned k = 0; k < mw; k++) cyc(1'b0, 1'b0, {nm, ".mwait"}, e);
      e.retire = (op == 4'd2);
      cyc(1'b0, 1'b1, {nm, ".mem"}, e);
      if (op == 4'd2) return;
    end
    e = '0; e.reg_we = 1'b1; e.retire = 1'b1;
    e.reg_dst = (op == 4'd0); e.wb_sel = (op == 4'd1);
    cyc(1'b0, 1'b0, {nm, ".wb"}, e);
  endtask

  initial begin
    outs_t e;
    @(posedge clk);
    #1;
    do_reset();

    e = '0;
    cyc(1'b0, 1'b1, "idle_ack", e);
    cyc(1'b0, 1'b1, "idle_ack", e);

    instr(16'h3123, 1'b0, 0, 0, "addi");
    instr(16'h1456, 1'b0, 0, 3, "lw_wait3");
    instr(16'h4000, 1'b1, 0, 0, "beq_taken");
    instr(16'h5000, 1'b1, 0, 0, "bne_not");
    instr(16'h4000, 1'b0, 0, 0, "beq_not");
    instr(16'h5000, 1'b0, 0, 0, "bne_taken");
    instr(16'h0122, 1'b0, 0, 0, "r_sll");
    instr(16'h0343, 1'b0, 1, 0, "r_and");
    instr(16'h2000, 1'b0, 2, 1, "sw");
    instr(16'h6abc, 1'b0, 1, 0, "jmp");
    instr(16'h1000, 1'b0, 2, 0, "lw_fw2");

    instr(16'h9000, 1'b0, 0, 0, "ill_op9");
    do_reset();
    instr(16'h0007, 1'b0, 0, 0, "ill_fn7");
    do_reset();

    e = '0; e.mem_req = 1'b1;
    for (int unsigned k = 0; k < 16; k++) cyc(1'b1, 1'b0, "tmo_wait", e);
    e = '0; e.fault = 1'b1;
    for (int unsigned k = 0; k < 3; k++) cyc(1'b1, 1'b1, "tmo_fault", e);
    do_reset();

    e = '0;
    for (int unsigned k = 0; k < 20; k++) cyc(1'b0, 1'b0, "run0_idle", e);
    instr(16'h3001, 1'b0, 0, 0, "addi_after_idle");

    ir = 16'hF00F;
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    cyc(1'b1, 1'b1, "rlw.fetch", e);
    ir = 16'h1000;
    e = '0;
    cyc(1'b0, 1'b0, "rlw.decode", e);
    e = '0; e.alu_src = 1'b1;
    cyc(1'b0, 1'b0, "rlw.exec", e);
    e = '0; e.mem_req = 1'b1;
    cyc(1'b0, 1'b0, "rlw.mwait", e);
    cyc(1'b0, 1'b0, "rlw.mwait", e);
    rst_n = 1'b0;
    e = '0;
    cyc(1'b0, 1'b1, "rlw.rst", e);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, "rlw.after_rst", e);
    instr(16'h3005, 1'b0, 0, 0, "addi_restart");

    @(negedge clk);
    #1;
    check("drain", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
